// File: rtl/plot_arbiter_pkg.sv
// plot_arbiter_pkg: shared types and constants for the renderer-to-VGA pixel merge stage.
//   x_width/y_width : coordinate bit widths for a given screen dimension
//   pixel_t         : one buffered pixel {x, y, colour}
//   BLACK/WHITE     : colour constants
package plot_arbiter_pkg;

    function automatic int unsigned x_width(input int unsigned pixels);
        return $clog2(pixels) + 1;
    endfunction

    function automatic int unsigned y_width(input int unsigned pixels);
        return $clog2(pixels) + 1;
    endfunction

    localparam int unsigned PIX_XW   = x_width(320);
    localparam int unsigned PIX_YW   = y_width(240);
    localparam int unsigned COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

    typedef struct packed {
        logic [PIX_XW-1:0]   x;
        logic [PIX_YW-1:0]   y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    localparam int unsigned PIXEL_W = $bits(pixel_t);

endpackage

// File: rtl/plot_arbiter_if.sv
// plot_arbiter_if: pixel bus between the two renderers, the merge stage and the VGA adapter.
//   i*A / i*B : per-source pixel, plot strobe and frame-complete pulse
//   o*        : merged pixel stream, frame-done pulse, FIFO full flags, sticky overflow
//   slave     : view used by plot_arbiter; master: view used by the driving side
interface plot_arbiter_if #(
    parameter int unsigned XW = plot_arbiter_pkg::PIX_XW,
    parameter int unsigned YW = plot_arbiter_pkg::PIX_YW
) ();

    logic [XW-1:0] iXA;
    logic [YW-1:0] iYA;
    logic [2:0]    iColourA;
    logic          iPlotA;
    logic          iNewFrameA;

    logic [XW-1:0] iXB;
    logic [YW-1:0] iYB;
    logic [2:0]    iColourB;
    logic          iPlotB;
    logic          iNewFrameB;

    logic [XW-1:0] oX;
    logic [YW-1:0] oY;
    logic [2:0]    oColour;
    logic          oPlot;
    logic          oFrameDone;
    logic          oFullA;
    logic          oFullB;
    logic          oOverflow;

    modport master (
        output iXA, iYA, iColourA, iPlotA, iNewFrameA,
        output iXB, iYB, iColourB, iPlotB, iNewFrameB,
        input  oX, oY, oColour, oPlot, oFrameDone, oFullA, oFullB, oOverflow
    );

    modport slave (
        input  iXA, iYA, iColourA, iPlotA, iNewFrameA,
        input  iXB, iYB, iColourB, iPlotB, iNewFrameB,
        output oX, oY, oColour, oPlot, oFrameDone, oFullA, oFullB, oOverflow
    );

endinterface

// File: rtl/plot_arbiter_pix_fifo.sv
// pix_fifo: synchronous show-ahead FIFO, DEPTH a power of two.
//   push/din  : write when not full (a push while full is ignored)
//   pop/dout  : dout is the head entry; pop advances when not empty
//   empty/full/count : registered occupancy status
module pix_fifo #(
    parameter int unsigned WIDTH = 22,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nxt;

    // Qualified push/pop and next occupancy
    always_comb begin
        do_push   = push && !full;
        do_pop    = pop && !empty;
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // Pointers and status flags; flags registered from the next count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

    // Storage needs no reset: nothing is read until it has been written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: merges the paddle and ball renderer pixel streams into one VGA pixel stream.
//   iClock/iResetn : clock, async active-low reset
//   bus (slave)    : per-source pixel inputs with plot and frame pulses; merged registered
//                    pixel output, frame-done pulse, per-source full flags, sticky overflow
// Each source is buffered in its own FIFO; a round-robin arbiter issues at most one pixel
// per clock. Frame-done fires once both sources have ended their frame and all their
// pixels have been issued.
module plot_arbiter
    import plot_arbiter_pkg::*;
#(
    parameter int unsigned X_SCREEN_PIXELS = 320,
    parameter int unsigned Y_SCREEN_PIXELS = 240,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic          iClock,
    input  logic          iResetn,
    plot_arbiter_if.slave bus
);

    localparam int unsigned XW = x_width(X_SCREEN_PIXELS);
    localparam int unsigned YW = y_width(Y_SCREEN_PIXELS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    pixel_t        pix_in_a;
    pixel_t        pix_in_b;
    pixel_t        head_a;
    pixel_t        head_b;
    pixel_t        pix_q;
    logic          empty_a;
    logic          empty_b;
    logic          full_a;
    logic          full_b;
    logic [CW-1:0] count_a;
    logic [CW-1:0] count_b;
    logic          pop_a;
    logic          pop_b;
    logic          frame_fire;
    logic          last_b;
    logic          plot_q;
    logic          frame_done_q;
    logic          overflow_q;
    logic          done_a;
    logic          done_b;

    pix_fifo #(.WIDTH(PIXEL_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk   (iClock),
        .rst_n (iResetn),
        .push  (bus.iPlotA),
        .pop   (pop_a),
        .din   (pix_in_a),
        .dout  (head_a),
        .empty (empty_a),
        .full  (full_a),
        .count (count_a)
    );

    pix_fifo #(.WIDTH(PIXEL_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk   (iClock),
        .rst_n (iResetn),
        .push  (bus.iPlotB),
        .pop   (pop_b),
        .din   (pix_in_b),
        .dout  (head_b),
        .empty (empty_b),
        .full  (full_b),
        .count (count_b)
    );

    // Input packing, round-robin grant (ties go to the source not granted last), frame fire
    always_comb begin
        pix_in_a = '{x: PIX_XW'(bus.iXA), y: PIX_YW'(bus.iYA), colour: bus.iColourA};
        pix_in_b = '{x: PIX_XW'(bus.iXB), y: PIX_YW'(bus.iYB), colour: bus.iColourB};
        pop_a    = 1'b0;
        pop_b    = 1'b0;
        if (!empty_a && (empty_b || last_b)) begin
            pop_a = 1'b1;
        end else if (!empty_b) begin
            pop_b = 1'b1;
        end
        frame_fire = done_a && done_b && (count_a == '0) && (count_b == '0)
                     && !pop_a && !pop_b;
    end

    // Output register, grant pointer, frame flags and sticky overflow
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            pix_q        <= '{x: '0, y: '0, colour: BLACK};
            plot_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            done_a       <= 1'b0;
            done_b       <= 1'b0;
            last_b       <= 1'b1;
        end else begin
            plot_q <= pop_a || pop_b;
            if (pop_a) begin
                pix_q  <= head_a;
                last_b <= 1'b0;
            end else if (pop_b) begin
                pix_q  <= head_b;
                last_b <= 1'b1;
            end
            frame_done_q <= frame_fire;
            overflow_q   <= overflow_q || (bus.iPlotA && full_a) || (bus.iPlotB && full_b);
            // A repeat frame pulse while the flag is set is absorbed; firing clears both
            done_a <= !frame_fire && (done_a || bus.iNewFrameA);
            done_b <= !frame_fire && (done_b || bus.iNewFrameB);
        end
    end

    assign bus.oX         = XW'(pix_q.x);
    assign bus.oY         = YW'(pix_q.y);
    assign bus.oColour    = pix_q.colour;
    assign bus.oPlot      = plot_q;
    assign bus.oFrameDone = frame_done_q;
    assign bus.oFullA     = full_a;
    assign bus.oFullB     = full_b;
    assign bus.oOverflow  = overflow_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: directed self-checking bench for plot_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_plot_arbiter;
    import plot_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    int t2_x [8] = '{1, 101, 2, 102, 3, 103, 4, 104};
    int t4_x [7] = '{1, 2, 101, 3, 102, 103, 104};

    plot_arbiter_if #(.XW(10), .YW(9)) bus ();

    plot_arbiter #(
        .X_SCREEN_PIXELS (320),
        .Y_SCREEN_PIXELS (240),
        .FIFO_DEPTH      (8)
    ) dut (
        .iClock  (clk),
        .iResetn (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_x"},        32'(bus.oX),       0);
        check({tag, "_y"},        32'(bus.oY),       0);
        check({tag, "_colour"},   32'(bus.oColour),  0);
        check({tag, "_plot"},     32'(bus.oPlot),    0);
        check({tag, "_fdone"},    32'(bus.oFrameDone), 0);
        check({tag, "_fulla"},    32'(bus.oFullA),   0);
        check({tag, "_fullb"},    32'(bus.oFullB),   0);
        check({tag, "_overflow"}, 32'(bus.oOverflow), 0);
    endtask

    task automatic idle();
        bus.iXA = '0; bus.iYA = '0; bus.iColourA = '0; bus.iPlotA = 1'b0; bus.iNewFrameA = 1'b0;
        bus.iXB = '0; bus.iYB = '0; bus.iColourB = '0; bus.iPlotB = 1'b0; bus.iNewFrameB = 1'b0;
    endtask

    task automatic drive_a(input int x, input int y, input int c);
        bus.iXA = 10'(x); bus.iYA = 9'(y); bus.iColourA = 3'(c); bus.iPlotA = 1'b1;
    endtask

    task automatic drive_b(input int x, input int y, input int c);
        bus.iXB = 10'(x); bus.iYB = 9'(y); bus.iColourB = 3'(c); bus.iPlotB = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int  ex;
        logic ep;

        // Reset state
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        check_zero("reset");
        tick();
        rst_n = 1'b1;

        // Single pixel latency: pushed at edge 1, visible after edge 2, gone after edge 3
        drive_a(10, 120, int'(WHITE));
        tick();
        idle();
        check("t1_plot_e1", 32'(bus.oPlot), 0);
        tick();
        check("t1_plot_e2",   32'(bus.oPlot),   1);
        check("t1_x_e2",      32'(bus.oX),      10);
        check("t1_y_e2",      32'(bus.oY),      120);
        check("t1_colour_e2", 32'(bus.oColour), 7);
        tick();
        check("t1_plot_e3", 32'(bus.oPlot), 0);
        check("t1_xhold_e3", 32'(bus.oX), 10);

        // Dual stream, round robin interleave with A winning the first tie
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            idle();
            if (n <= 4) begin
                drive_a(n, 0, 1);
                drive_b(100 + n, 0, 2);
            end
            tick();
            if (n >= 2 && n <= 9) begin
                check($sformatf("t2_plot_e%0d", n), 32'(bus.oPlot), 1);
                check($sformatf("t2_x_e%0d", n), 32'(bus.oX), 32'(t2_x[n-2]));
            end else begin
                check($sformatf("t2_plot_e%0d", n), 32'(bus.oPlot), 0);
            end
        end

        // Overflow: A pushes 16 times at half drain rate; full after edge 15, 16th pixel dropped
        do_reset();
        for (int n = 1; n <= 26; n++) begin
            idle();
            if (n <= 16) drive_a(n, 0, 3);
            if (n <= 8)  drive_b(200 + n, 0, 4);
            tick();
            ep = 1'b1;
            ex = 0;
            if (n >= 2 && n <= 16 && (n % 2) == 0) ex = n / 2;
            else if (n >= 3 && n <= 17)            ex = 200 + (n - 1) / 2;
            else if (n >= 18 && n <= 24)           ex = n - 9;
            else                                   ep = 1'b0;
            check($sformatf("t3_plot_e%0d", n), 32'(bus.oPlot), 32'(ep));
            if (ep) check($sformatf("t3_x_e%0d", n), 32'(bus.oX), 32'(ex));
            if (n == 14) check("t3_fulla_e14", 32'(bus.oFullA), 0);
            if (n == 15) begin
                check("t3_fulla_e15", 32'(bus.oFullA), 1);
                check("t3_fullb_e15", 32'(bus.oFullB), 0);
                check("t3_ovf_e15", 32'(bus.oOverflow), 0);
            end
            if (n == 16) begin
                check("t3_fulla_e16", 32'(bus.oFullA), 0);
                check("t3_ovf_e16", 32'(bus.oOverflow), 1);
            end
            if (n == 26) check("t3_ovf_sticky", 32'(bus.oOverflow), 1);
        end

        // Frame done: A ends at edge 3, B ends at edge 6 with pixels still queued
        do_reset();
        for (int n = 1; n <= 13; n++) begin
            idle();
            if (n <= 3)           drive_a(n, 0, 5);
            if (n >= 3 && n <= 6) drive_b(98 + n, 0, 6);
            if (n == 3 || n == 7) bus.iNewFrameA = 1'b1;
            if (n == 6 || n == 11) bus.iNewFrameB = 1'b1;
            tick();
            if (n >= 2 && n <= 8) begin
                check($sformatf("t4_plot_e%0d", n), 32'(bus.oPlot), 1);
                check($sformatf("t4_x_e%0d", n), 32'(bus.oX), 32'(t4_x[n-2]));
            end else begin
                check($sformatf("t4_plot_e%0d", n), 32'(bus.oPlot), 0);
            end
            check($sformatf("t4_fdone_e%0d", n), 32'(bus.oFrameDone), (n == 9) ? 1 : 0);
        end

        // Asynchronous reset mid-stream with five pixels pushed
        do_reset();
        for (int n = 1; n <= 3; n++) begin
            idle();
            drive_a(n + 20, 5, 1);
            if (n <= 2) drive_b(n + 50, 6, 2);
            tick();
        end
        idle();
        check("t5_plot_before", 32'(bus.oPlot), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t5_async");
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            tick();
            check($sformatf("t5_plot_after%0d", n), 32'(bus.oPlot), 0);
        end
        check("t5_x_after", 32'(bus.oX), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
